// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response bundle used for the instruction requester, the
// data requester and the shared downstream memory port.
//   req/wr/size/wstrb/addr/wdata : request, driven by the master side
//   addr_ok                      : request accepted this cycle
//   data_ok/rdata                : response (read data or write completion)
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one downstream SRAM-like port between the instruction-fetch and the
// EX-stage data requesters. Data has fixed priority over instruction. A grant
// that is not yet accepted stays locked until the downstream addr_ok arrives.
// The requester ID of every accepted transaction goes into an in-order FIFO,
// so each response goes back to the requester that issued it.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   inst_if     : instruction requester (slave side)
//   data_if     : data requester (slave side)
//   mem_if      : shared downstream port (master side)
//   resp_err    : sticky, set when a response arrives with no outstanding ID
module sram_req_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                clk,
  input  logic                resetn,
  sram_req_arbiter_if.slave   inst_if,
  sram_req_arbiter_if.slave   data_if,
  sram_req_arbiter_if.master  mem_if,
  output logic                resp_err
);

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  lock_state_e      lock_q, lock_d;
  logic             lock_id_q, lock_id_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] id_fifo_q, id_fifo_d;
  logic             resp_err_q, resp_err_d;

  logic grant_vld;
  logic grant_id;
  logic fifo_full;
  logic fifo_empty;
  logic head_id;
  logic push;
  logic pop;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign head_id    = id_fifo_q[rd_ptr_q];

  // Grant is forced idle while reset is held so that no request or handshake
  // leaks out combinationally from requesters that are already asserting req.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = ID_INST;
    if (!resetn) begin
      grant_vld = 1'b0;
    end else if (lock_q == LOCKED) begin
      grant_vld = 1'b1;
      grant_id  = lock_id_q;
    end else if (data_if.req) begin
      grant_vld = 1'b1;
      grant_id  = ID_DATA;
    end else if (inst_if.req) begin
      grant_vld = 1'b1;
      grant_id  = ID_INST;
    end
  end

  // Downstream request mux; all fields are zero when nothing is granted.
  always_comb begin
    mem_if.req   = 1'b0;
    mem_if.wr    = 1'b0;
    mem_if.size  = '0;
    mem_if.wstrb = '0;
    mem_if.addr  = '0;
    mem_if.wdata = '0;
    if (grant_vld) begin
      if (grant_id == ID_DATA) begin
        mem_if.req   = data_if.req & ~fifo_full;
        mem_if.wr    = data_if.wr;
        mem_if.size  = data_if.size;
        mem_if.wstrb = data_if.wstrb;
        mem_if.addr  = data_if.addr;
        mem_if.wdata = data_if.wdata;
      end else begin
        mem_if.req   = inst_if.req & ~fifo_full;
        mem_if.wr    = inst_if.wr;
        mem_if.size  = inst_if.size;
        mem_if.wstrb = inst_if.wstrb;
        mem_if.addr  = inst_if.addr;
        mem_if.wdata = inst_if.wdata;
      end
    end
  end

  assign push = mem_if.req & mem_if.addr_ok;
  assign pop  = resetn & mem_if.data_ok & ~fifo_empty;

  // Responses are routed by the head entry as it stood before this edge's pop.
  always_comb begin
    inst_if.addr_ok = push & (grant_id == ID_INST);
    data_if.addr_ok = push & (grant_id == ID_DATA);
    inst_if.data_ok = pop & (head_id == ID_INST);
    data_if.data_ok = pop & (head_id == ID_DATA);
    inst_if.rdata   = mem_if.rdata;
    data_if.rdata   = mem_if.rdata;
  end

  assign resp_err = resp_err_q;

  // Lock FSM: hold the grant on a requester whose request is not yet accepted.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    case (lock_q)
      UNLOCKED: begin
        if (mem_if.req && !mem_if.addr_ok) begin
          lock_d    = LOCKED;
          lock_id_d = grant_id;
        end
      end
      LOCKED: begin
        if (mem_if.req && mem_if.addr_ok) begin
          lock_d = UNLOCKED;
        end
      end
      default: lock_d = UNLOCKED;
    endcase
  end

  // ID FIFO bookkeeping and sticky error flag.
  always_comb begin
    id_fifo_d  = id_fifo_q;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    resp_err_d = resp_err_q | (mem_if.data_ok & fifo_empty);
    if (push) begin
      id_fifo_d[wr_ptr_q] = grant_id;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q     <= UNLOCKED;
      lock_id_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      resp_err_q <= resp_err_d;
    end
  end

  // ID storage is only read through valid pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    id_fifo_q <= id_fifo_d;
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: arbitration priority, lock, response
// routing, FIFO full, spurious response and asynchronous reset.
module tb_sram_req_arbiter;

  logic clk;
  logic resetn;
  logic resp_err;

  int n_chk;
  int n_bad;

  sram_req_arbiter_if inst_if ();
  sram_req_arbiter_if data_if ();
  sram_req_arbiter_if mem_if ();

  sram_req_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .inst_if  (inst_if),
    .data_if  (data_if),
    .mem_if   (mem_if),
    .resp_err (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock: inputs change on the falling edge, checks follow #1.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    resetn         = 1'b0;
    inst_if.req    = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2;
    inst_if.wstrb  = 4'h0; inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
    data_if.req    = 1'b1; data_if.wr = 1'b1; data_if.size = 2'd2;
    data_if.wstrb  = 4'hf; data_if.addr = 32'h0000_1000; data_if.wdata = 32'hdead_beef;
    mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b0; mem_if.rdata = 32'h0;

    // Reset held with a live data request: everything downstream stays quiet.
    #1;
    chk("rst_mem_req",   mem_if.req, 0);
    chk("rst_mem_addr",  mem_if.addr, 0);
    chk("rst_mem_wdata", mem_if.wdata, 0);
    chk("rst_d_addr_ok", data_if.addr_ok, 0);
    chk("rst_resp_err",  resp_err, 0);

    @(negedge clk);
    resetn = 1'b1;

    // Simultaneous request: data first, then instruction.
    inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0000;
    #1;
    chk("sim0_mem_addr",  mem_if.addr, 32'h0000_1000);
    chk("sim0_mem_wr",    mem_if.wr, 1);
    chk("sim0_mem_wdata", mem_if.wdata, 32'hdead_beef);
    chk("sim0_mem_wstrb", mem_if.wstrb, 4'hf);
    chk("sim0_d_addr_ok", data_if.addr_ok, 1);
    chk("sim0_i_addr_ok", inst_if.addr_ok, 0);
    @(negedge clk);
    data_if.req = 1'b0;
    #1;
    chk("sim1_mem_addr",  mem_if.addr, 32'h1c00_0000);
    chk("sim1_mem_wr",    mem_if.wr, 0);
    chk("sim1_i_addr_ok", inst_if.addr_ok, 1);
    chk("sim1_d_addr_ok", data_if.addr_ok, 0);
    @(negedge clk);
    inst_if.req = 1'b0;
    #1;
    chk("idle_mem_req",  mem_if.req, 0);
    chk("idle_mem_addr", mem_if.addr, 0);

    // Responses come back in order: DATA then INST.
    @(negedge clk);
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'haaaa_5555;
    #1;
    chk("rsp0_d_data_ok", data_if.data_ok, 1);
    chk("rsp0_i_data_ok", inst_if.data_ok, 0);
    chk("rsp0_d_rdata",   data_if.rdata, 32'haaaa_5555);
    @(negedge clk);
    mem_if.rdata = 32'h1234_5678;
    #1;
    chk("rsp1_i_data_ok", inst_if.data_ok, 1);
    chk("rsp1_d_data_ok", data_if.data_ok, 0);
    chk("rsp1_i_rdata",   inst_if.rdata, 32'h1234_5678);
    @(negedge clk);
    mem_if.data_ok = 1'b0; mem_if.rdata = 32'h0;
    #1;
    chk("rsp_resp_err", resp_err, 0);

    // Lock: instruction request stalls downstream, data arrives later.
    @(negedge clk);
    inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0040; mem_if.addr_ok = 1'b0;
    data_if.wr = 1'b0; data_if.addr = 32'h0000_2000;
    #1;
    chk("lk0_mem_addr",  mem_if.addr, 32'h1c00_0040);
    chk("lk0_i_addr_ok", inst_if.addr_ok, 0);
    @(negedge clk);
    data_if.req = 1'b1;
    #1;
    chk("lk1_mem_addr",  mem_if.addr, 32'h1c00_0040);
    chk("lk1_mem_req",   mem_if.req, 1);
    chk("lk1_d_addr_ok", data_if.addr_ok, 0);
    step();
    chk("lk2_mem_addr",  mem_if.addr, 32'h1c00_0040);
    @(negedge clk);
    mem_if.addr_ok = 1'b1;
    #1;
    chk("lk3_mem_addr",  mem_if.addr, 32'h1c00_0040);
    chk("lk3_i_addr_ok", inst_if.addr_ok, 1);
    chk("lk3_d_addr_ok", data_if.addr_ok, 0);
    @(negedge clk);
    inst_if.req = 1'b0;
    #1;
    chk("lk4_mem_addr",  mem_if.addr, 32'h0000_2000);
    chk("lk4_d_addr_ok", data_if.addr_ok, 1);
    @(negedge clk);
    data_if.req = 1'b0;
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0000_0011;
    #1;
    chk("lkr0_i_data_ok", inst_if.data_ok, 1);
    chk("lkr0_d_data_ok", data_if.data_ok, 0);
    step();
    chk("lkr1_d_data_ok", data_if.data_ok, 1);
    chk("lkr1_i_data_ok", inst_if.data_ok, 0);
    @(negedge clk);
    mem_if.data_ok = 1'b0;

    // Full: four accepted data requests, then back-pressure.
    data_if.req = 1'b1; data_if.addr = 32'h0000_3000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("full_acc%0d", i), data_if.addr_ok, 1);
      @(negedge clk);
    end
    #1;
    chk("full_mem_req",   mem_if.req, 0);
    chk("full_d_addr_ok", data_if.addr_ok, 0);
    @(negedge clk);
    mem_if.data_ok = 1'b1;
    #1;
    chk("fullpop_mem_req",   mem_if.req, 0);
    chk("fullpop_d_data_ok", data_if.data_ok, 1);
    @(negedge clk);
    mem_if.data_ok = 1'b0;
    #1;
    chk("refill_mem_req",   mem_if.req, 1);
    chk("refill_d_addr_ok", data_if.addr_ok, 1);
    @(negedge clk);
    data_if.req = 1'b0;
    mem_if.data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain%0d_d_data_ok", i), data_if.data_ok, 1);
      @(negedge clk);
    end

    // Spurious response with the FIFO empty.
    #1;
    chk("spur_d_data_ok", data_if.data_ok, 0);
    chk("spur_i_data_ok", inst_if.data_ok, 0);
    chk("spur_err_pre",   resp_err, 0);
    @(negedge clk);
    mem_if.data_ok = 1'b0;
    #1;
    chk("spur_err_set", resp_err, 1);
    step();
    chk("spur_err_hold", resp_err, 1);

    // Asynchronous reset with two transactions outstanding.
    @(negedge clk);
    data_if.req = 1'b1; data_if.addr = 32'h0000_4000;
    step();
    @(negedge clk);
    #2;
    resetn = 1'b0;
    mem_if.data_ok = 1'b1;
    #1;
    chk("arst_mem_req",   mem_if.req, 0);
    chk("arst_mem_addr",  mem_if.addr, 0);
    chk("arst_d_addr_ok", data_if.addr_ok, 0);
    chk("arst_d_data_ok", data_if.data_ok, 0);
    chk("arst_resp_err",  resp_err, 0);
    @(negedge clk);
    data_if.req = 1'b0; mem_if.data_ok = 1'b0; mem_if.addr_ok = 1'b0;
    resetn = 1'b1;
    #1;
    chk("post_resp_err", resp_err, 0);
    @(negedge clk);
    mem_if.data_ok = 1'b1;
    #1;
    chk("post_d_data_ok", data_if.data_ok, 0);
    chk("post_i_data_ok", inst_if.data_ok, 0);
    @(negedge clk);
    mem_if.data_ok = 1'b0;
    #1;
    chk("post_err_set", resp_err, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
